data_decoder: RTL and testbench

DATA_DECODER -- requirements
Module: data_decoder

---
 rtl/data_decoder_if.sv | 34 +++
 rtl/data_decoder.sv | 158 +++++++++++++++
 tb/tb_data_decoder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_decoder_if.sv
// data_decoder_if -- bus bundle between a word source and data_decoder.
//   pre_en / pre_data    : incoming word stream (no backpressure)
//   post_en / post_data  : forwarded payload words
//   frame_done, frame_ok : end-of-frame pulse and status of the last frame
//   err_tail, err_chk, err_timeout : cause flags of the last frame
//   frame_cnt, err_cnt   : saturating good / bad frame counters
// Modports: master = word source / status consumer, slave = decoder.
interface data_decoder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  pre_en;
    logic [DATA_WIDTH-1:0] pre_data;
    logic                  post_en;
    logic [DATA_WIDTH-1:0] post_data;
    logic                  frame_done;
    logic                  frame_ok;
    logic                  err_tail;
    logic                  err_chk;
    logic                  err_timeout;
    logic [15:0]           frame_cnt;
    logic [15:0]           err_cnt;

    modport master (
        output pre_en, pre_data,
        input  post_en, post_data, frame_done, frame_ok,
        input  err_tail, err_chk, err_timeout, frame_cnt, err_cnt
    );

    modport slave (
        input  pre_en, pre_data,
        output post_en, post_data, frame_done, frame_ok,
        output err_tail, err_chk, err_timeout, frame_cnt, err_cnt
    );
endinterface

// File: rtl/data_decoder.sv
// data_decoder -- frame parser for a word stream of the form
//   DATA_SIZE payload words, one tail word, one check word,
// where check = ~(payload sum + tail word) modulo 2^DATA_WIDTH.
// Payload words are forwarded one cycle after acceptance; tail and check
// words are consumed. Each frame ends with a one-cycle frame_done pulse and
// a status/cause report; a frame stalled for TIMEOUT idle cycles is aborted.
// Ports:
//   sys_clk  : clock, rising edge
//   sys_rst  : asynchronous active-high reset
//   bus      : data_decoder_if slave modport (input stream, payload output,
//              frame status, error flags, frame counters)
module data_decoder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DATA_SIZE  = 65537,
    parameter logic [DATA_WIDTH-1:0] TAIL_WORD  = 32'h5A5A_A5A5,
    parameter int                    TIMEOUT    = 1024
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    data_decoder_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_SIZE + 1);
    localparam int GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_SIZE - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL,
        ST_CHECK
    } state_t;

    state_t                state_reg;
    logic [CNT_W-1:0]      word_cnt_reg;
    logic [GAP_W-1:0]      gap_reg;
    logic [DATA_WIDTH-1:0] sum_reg;
    logic                  tail_bad_reg;
    logic                  post_en_reg;
    logic [DATA_WIDTH-1:0] post_data_reg;
    logic                  frame_done_reg;
    logic                  frame_ok_reg;
    logic                  err_tail_reg;
    logic                  err_chk_reg;
    logic                  err_timeout_reg;
    logic [15:0]           frame_cnt_reg;
    logic [15:0]           err_cnt_reg;

    logic tail_bad;
    logic chk_bad;

    assign tail_bad = (bus.pre_data != TAIL_WORD);
    // sum_reg already includes the tail word when the check word arrives
    assign chk_bad  = (bus.pre_data != ~sum_reg);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg       <= ST_IDLE;
            word_cnt_reg    <= '0;
            gap_reg         <= '0;
            sum_reg         <= '0;
            tail_bad_reg    <= 1'b0;
            post_en_reg     <= 1'b0;
            post_data_reg   <= '0;
            frame_done_reg  <= 1'b0;
            frame_ok_reg    <= 1'b0;
            err_tail_reg    <= 1'b0;
            err_chk_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
            frame_cnt_reg   <= '0;
            err_cnt_reg     <= '0;
        end else begin
            post_en_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // No gap counting here: an idle line between frames is legal.
                    if (bus.pre_en) begin
                        post_en_reg     <= 1'b1;
                        post_data_reg   <= bus.pre_data;
                        sum_reg         <= bus.pre_data;
                        word_cnt_reg    <= CNT_W'(1);
                        gap_reg         <= '0;
                        tail_bad_reg    <= 1'b0;
                        err_tail_reg    <= 1'b0;
                        err_chk_reg     <= 1'b0;
                        err_timeout_reg <= 1'b0;
                        state_reg       <= (DATA_SIZE == 1) ? ST_TAIL : ST_DATA;
                    end
                end
                default: begin
                    if (bus.pre_en) begin
                        gap_reg <= '0;
                        case (state_reg)
                            ST_DATA: begin
                                post_en_reg   <= 1'b1;
                                post_data_reg <= bus.pre_data;
                                sum_reg       <= sum_reg + bus.pre_data;
                                word_cnt_reg  <= word_cnt_reg + CNT_W'(1);
                                if (word_cnt_reg == LAST_IDX) begin
                                    state_reg <= ST_TAIL;
                                end
                            end
                            ST_TAIL: begin
                                // A bad tail is only reported; the frame continues.
                                tail_bad_reg <= tail_bad;
                                sum_reg      <= sum_reg + bus.pre_data;
                                state_reg    <= ST_CHECK;
                            end
                            default: begin
                                frame_done_reg <= 1'b1;
                                frame_ok_reg   <= !(tail_bad_reg || chk_bad);
                                err_tail_reg   <= tail_bad_reg;
                                err_chk_reg    <= chk_bad;
                                if (!(tail_bad_reg || chk_bad)) begin
                                    if (frame_cnt_reg != 16'hFFFF) begin
                                        frame_cnt_reg <= frame_cnt_reg + 16'd1;
                                    end
                                end else if (err_cnt_reg != 16'hFFFF) begin
                                    err_cnt_reg <= err_cnt_reg + 16'd1;
                                end
                                sum_reg      <= '0;
                                word_cnt_reg <= '0;
                                state_reg    <= ST_IDLE;
                            end
                        endcase
                    end else if (gap_reg == GAP_LAST) begin
                        // This idle cycle is the TIMEOUT-th in a row: abort.
                        frame_done_reg  <= 1'b1;
                        frame_ok_reg    <= 1'b0;
                        err_timeout_reg <= 1'b1;
                        err_tail_reg    <= tail_bad_reg;
                        err_chk_reg     <= 1'b0;
                        if (err_cnt_reg != 16'hFFFF) begin
                            err_cnt_reg <= err_cnt_reg + 16'd1;
                        end
                        gap_reg      <= '0;
                        sum_reg      <= '0;
                        word_cnt_reg <= '0;
                        state_reg    <= ST_IDLE;
                    end else begin
                        gap_reg <= gap_reg + GAP_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.post_en     = post_en_reg;
    assign bus.post_data   = post_data_reg;
    assign bus.frame_done  = frame_done_reg;
    assign bus.frame_ok    = frame_ok_reg;
    assign bus.err_tail    = err_tail_reg;
    assign bus.err_chk     = err_chk_reg;
    assign bus.err_timeout = err_timeout_reg;
    assign bus.frame_cnt   = frame_cnt_reg;
    assign bus.err_cnt     = err_cnt_reg;
endmodule

// File: tb/tb_data_decoder.sv
// tb_data_decoder -- directed bench for data_decoder (DATA_SIZE=4,
// TIMEOUT=8). A frame-level model predicts every output each cycle and a
// single compare process checks the DUT against it; literal checks after
// each scenario pin the model to hand-computed results.
module tb_data_decoder;
    localparam int          DS   = 4;
    localparam int          TO   = 8;
    localparam logic [31:0] TAIL = 32'h5A5A_A5A5;
    localparam logic [31:0] GOOD = 32'hA5A5_5A50;

    logic sys_clk;
    logic sys_rst;

    data_decoder_if #(.DATA_WIDTH(32)) bus ();

    data_decoder #(
        .DATA_WIDTH(32),
        .DATA_SIZE (DS),
        .TAIL_WORD (TAIL),
        .TIMEOUT   (TO)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- frame-level model ----------------
    logic [31:0] fw[$];
    int          m_gap;
    logic        m_post_en;
    logic [31:0] m_post_data;
    logic        m_done, m_ok, m_et, m_ec, m_eto;
    logic [15:0] m_fc, m_ecnt;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fw.delete();
            m_gap = 0;
            m_post_en = 1'b0; m_post_data = '0;
            m_done = 1'b0; m_ok = 1'b0;
            m_et = 1'b0; m_ec = 1'b0; m_eto = 1'b0;
            m_fc = '0; m_ecnt = '0;
        end else begin
            m_post_en = 1'b0;
            m_done    = 1'b0;
            if (bus.pre_en) begin
                if (fw.size() == 0) begin
                    m_et = 1'b0; m_ec = 1'b0; m_eto = 1'b0;
                end
                fw.push_back(bus.pre_data);
                m_gap = 0;
                if (fw.size() <= DS) begin
                    m_post_en   = 1'b1;
                    m_post_data = bus.pre_data;
                end else if (fw.size() == DS + 2) begin
                    logic [31:0] s;
                    s = '0;
                    for (int i = 0; i <= DS; i++) s += fw[i];
                    m_et   = (fw[DS] != TAIL);
                    m_ec   = (fw[DS+1] != ~s);
                    m_eto  = 1'b0;
                    m_ok   = !(m_et || m_ec);
                    m_done = 1'b1;
                    if (m_ok) begin
                        if (m_fc != 16'hFFFF) m_fc++;
                    end else if (m_ecnt != 16'hFFFF) m_ecnt++;
                    fw.delete();
                end
            end else if (fw.size() > 0) begin
                m_gap++;
                if (m_gap == TO) begin
                    m_eto  = 1'b1;
                    m_et   = (fw.size() > DS) && (fw[DS] != TAIL);
                    m_ec   = 1'b0;
                    m_ok   = 1'b0;
                    m_done = 1'b1;
                    if (m_ecnt != 16'hFFFF) m_ecnt++;
                    fw.delete();
                    m_gap = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge sys_clk) begin
        n_vec++;
        if ({bus.post_en, bus.post_data, bus.frame_done, bus.frame_ok, bus.err_tail,
             bus.err_chk, bus.err_timeout, bus.frame_cnt, bus.err_cnt} !==
            {m_post_en, m_post_data, m_done, m_ok, m_et, m_ec, m_eto, m_fc, m_ecnt}) begin
            n_bad++;
            $display("FAIL cycle_outputs t=%0t: got en=%b d=%h done=%b ok=%b et=%b ec=%b eto=%b fc=%0d ecnt=%0d, need en=%b d=%h done=%b ok=%b et=%b ec=%b eto=%b fc=%0d ecnt=%0d",
                     $time, bus.post_en, bus.post_data, bus.frame_done, bus.frame_ok,
                     bus.err_tail, bus.err_chk, bus.err_timeout, bus.frame_cnt, bus.err_cnt,
                     m_post_en, m_post_data, m_done, m_ok, m_et, m_ec, m_eto, m_fc, m_ecnt);
        end
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc[$];
    logic        last_ok, last_et, last_ec, last_eto;
    logic [31:0] post_q[$];

    always @(negedge sys_clk) begin
        cyc++;
        if (bus.post_en) post_q.push_back(bus.post_data);
        if (bus.frame_done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            last_ok  = bus.frame_ok;
            last_et  = bus.err_tail;
            last_ec  = bus.err_chk;
            last_eto = bus.err_timeout;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [31:0] d);
        @(negedge sys_clk);
        bus.pre_en   = en;
        bus.pre_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom());
    endtask

    task automatic send6(input logic [31:0] a, b, c, d, t, k);
        drive(1'b1, a); drive(1'b1, b); drive(1'b1, c);
        drive(1'b1, d); drive(1'b1, t); drive(1'b1, k);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, 32'({bus.post_en, bus.frame_done, bus.frame_ok,
                                  bus.err_tail, bus.err_chk, bus.err_timeout}), 32'h0);
        chk({tag, "_post_data"}, bus.post_data, 32'h0);
        chk({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'h0);
        chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        sys_rst      = 1'b1;
        bus.pre_en   = 1'b0;
        bus.pre_data = '0;
        @(negedge sys_clk); #2;
        chk_all_zero("reset");
        sys_rst = 1'b0;

        // good frame
        post_q.delete();
        send6(32'd1, 32'd2, 32'd3, 32'd4, TAIL, GOOD);
        idle(3); #2;
        chk("good_post_count", 32'(post_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < post_q.size(); i++)
            chk("good_post_word", post_q[i], 32'(i + 1));
        chk("good_done_cnt", 32'(done_cnt), 32'd1);
        chk("good_ok", 32'(last_ok), 32'd1);
        chk("good_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        chk("hold_post_data", bus.post_data, 32'd4);
        $display("frame good: done=%0d ok=%b frame_cnt=%0d", done_cnt, last_ok, bus.frame_cnt);

        // bad check word
        send6(32'd1, 32'd2, 32'd3, 32'd4, TAIL, 32'hA5A5_5A51);
        idle(3); #2;
        chk("badchk_err_chk", 32'(last_ec), 32'd1);
        chk("badchk_err_tail", 32'(last_et), 32'd0);
        chk("badchk_ok", 32'(last_ok), 32'd0);
        chk("badchk_err_cnt", 32'(bus.err_cnt), 32'd1);
        $display("frame bad check: err_chk=%b err_cnt=%0d", last_ec, bus.err_cnt);

        // bad tail, check consistent with the zero tail
        send6(32'd1, 32'd2, 32'd3, 32'd4, 32'h0, 32'hFFFF_FFF5);
        idle(3); #2;
        chk("badtail_err_tail", 32'(last_et), 32'd1);
        chk("badtail_err_chk", 32'(last_ec), 32'd0);
        chk("badtail_ok", 32'(last_ok), 32'd0);
        chk("badtail_err_cnt", 32'(bus.err_cnt), 32'd2);
        $display("frame bad tail: err_tail=%b err_chk=%b", last_et, last_ec);

        // back-to-back frames
        post_q.delete();
        d0 = done_cnt;
        send6(32'd1, 32'd2, 32'd3, 32'd4, TAIL, GOOD);
        send6(32'd1, 32'd2, 32'd3, 32'd4, TAIL, GOOD);
        idle(3); #2;
        chk("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);
        if (done_cyc.size() >= 2)
            chk("b2b_done_spacing", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'd6);
        chk("b2b_post_count", 32'(post_q.size()), 32'd8);
        chk("b2b_frame_cnt", 32'(bus.frame_cnt), 32'd3);
        $display("back-to-back: pulses=%0d words=%0d frame_cnt=%0d", done_cnt - d0, post_q.size(), bus.frame_cnt);

        // timeout after two payload words
        d0 = done_cnt;
        drive(1'b1, 32'd1); drive(1'b1, 32'd2);
        idle(TO + 2); #2;
        chk("timeout_done", 32'(done_cnt - d0), 32'd1);
        chk("timeout_flag", 32'(last_eto), 32'd1);
        chk("timeout_ok", 32'(last_ok), 32'd0);
        chk("timeout_err_cnt", 32'(bus.err_cnt), 32'd3);
        $display("timeout: err_timeout=%b err_cnt=%0d", last_eto, bus.err_cnt);
        d0 = done_cnt;
        idle(20); #2;
        chk("idle_no_timeout", 32'(done_cnt - d0), 32'd0);
        send6(32'd1, 32'd2, 32'd3, 32'd4, TAIL, GOOD);
        idle(3); #2;
        chk("after_timeout_ok", 32'(last_ok), 32'd1);
        chk("after_timeout_eto", 32'(last_eto), 32'd0);
        chk("after_timeout_frame_cnt", 32'(bus.frame_cnt), 32'd4);
        $display("after timeout: ok=%b frame_cnt=%0d", last_ok, bus.frame_cnt);

        // reset in the middle of a frame
        d0 = done_cnt;
        drive(1'b1, 32'd1); drive(1'b1, 32'd2); drive(1'b1, 32'd3);
        drive(1'b0, 32'h0);
        #3 sys_rst = 1'b1;
        #1 chk_all_zero("midreset");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        send6(32'd1, 32'd2, 32'd3, 32'd4, TAIL, GOOD);
        idle(3); #2;
        chk("midreset_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("midreset_ok", 32'(last_ok), 32'd1);
        chk("midreset_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        chk("midreset_err_cnt", 32'(bus.err_cnt), 32'd0);
        $display("after mid-frame reset: ok=%b frame_cnt=%0d", last_ok, bus.frame_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
